// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the five-stage MIPS pipeline: load-use, branch-operand,
// taken-branch flush and multi-cycle EX stalls. Optional StallCycles counter via HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int unsigned LONG_LAT = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_Branch,
    input  logic       ID_BranchTaken,
    input  logic       EX_MemRead,
    input  logic       EX_RegWrite,
    input  logic [4:0] EX_Rd,
    input  logic       EX_LongOp,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_Rd,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Bubble,
    output logic       EX_MEM_Bubble,
    output logic       Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] StallCycles
`endif
);

    typedef enum logic {
        IDLE,
        LONG
    } state_t;

    // First LONG cycle is already the second stall cycle, hence LONG_LAT-2.
    localparam logic [3:0] CNT_INIT = 4'((LONG_LAT >= 2) ? (LONG_LAT - 2) : 0);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ls, lu, bs;
    logic       ex_match, mem_match;

    // Register 0 is hard-wired zero, so it can never carry a dependency.
    assign ex_match  = (EX_Rd != 5'd0) &&
                       ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));
    assign mem_match = (MEM_Rd != 5'd0) &&
                       ((MEM_Rd == ID_Rs) || (ID_UsesRt && (MEM_Rd == ID_Rt)));
    assign lu        = EX_MemRead && ex_match;
    assign bs        = ID_Branch && ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));

    // NOTE: asynchronous reset lives in the sensitivity list; state uses non-blocking assignments.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ls        = 1'b0;
        case (state)
            IDLE: begin
                if (EX_LongOp && (LONG_LAT > 1)) begin
                    ls        = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = LONG;
                end
            end
            LONG: begin
                if (cnt != 4'd0) begin
                    ls      = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        Busy          = (state == LONG);
        if (Reset) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            ID_EX_Bubble  = 1'b1;
            EX_MEM_Bubble = 1'b1;
            Busy          = 1'b0;
        end else if (ls) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (lu || bs) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            // A taken branch flushes only when nothing stalls; otherwise it is re-evaluated later.
            IF_ID_Flush = ID_BranchTaken;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCycles <= 32'd0;
        end else if (!PCWrite && (StallCycles != 32'hFFFF_FFFF)) begin
            StallCycles <= StallCycles + 32'd1;
        end
    end
`endif

endmodule
